// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage: fetch handshake, stall hold, prioritised redirects.
// Optional exception/eret support is enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_cur,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [31:0]      pc_next,
  output logic             imem_req,
  output logic             if_valid,
  output logic             misalign_err,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             redir;
  logic [31:0]      redir_tgt;
  logic             exc_take;
  logic             epc_cap;
  logic [31:0]      pc_inc;

  assign pc_inc = pc_cur + 32'd4;

`ifdef PC_SEQ_EXC_EN
  logic [31:0] epc_q;

  // Highest-priority redirect request and its target
  always_comb begin
    redir     = 1'b0;
    redir_tgt = 32'h0;
    exc_take  = 1'b0;
    if (exc_req) begin
      redir     = 1'b1;
      redir_tgt = EXC_VECTOR;
      exc_take  = 1'b1;
    end else if (eret) begin
      redir     = 1'b1;
      redir_tgt = epc_q;
    end else if (jump) begin
      redir     = 1'b1;
      redir_tgt = jump_target;
    end else if (branch_taken) begin
      redir     = 1'b1;
      redir_tgt = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q <= 32'h0;
    end else if (epc_cap) begin
      epc_q <= pc_cur;
    end
  end

  assign epc = epc_q;
`else
  logic unused_exc;

  // Exception inputs have no effect in this build
  always_comb begin
    redir     = 1'b0;
    redir_tgt = 32'h0;
    exc_take  = 1'b0;
    if (jump) begin
      redir     = 1'b1;
      redir_tgt = jump_target;
    end else if (branch_taken) begin
      redir     = 1'b1;
      redir_tgt = branch_target;
    end
  end

  assign unused_exc = ^{exc_req, eret, EXC_VECTOR, epc_cap, exc_take};
  assign epc        = 32'h0;
`endif

  // Next-state, next-PC and fetch-side outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mis_d    = 1'b0;
    epc_cap  = 1'b0;
    pc_next  = 32'h0;
    imem_req = 1'b0;
    if_valid = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          imem_req = 1'b1;
          if (redir) begin
            pc_next = {redir_tgt[31:2], 2'b00};
            mis_d   = |redir_tgt[1:0];
            epc_cap = exc_take;
            state_d = ST_FETCH;
          end else if (!imem_ready) begin
            pc_next = pc_cur;
          end else if (!stall) begin
            if_valid = 1'b1;
            pc_next  = pc_inc;
            cnt_d    = cnt_q + CNT_W'(1);
          end else begin
            if_valid = 1'b1;
            pc_next  = pc_cur;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redir) begin
            pc_next = {redir_tgt[31:2], 2'b00};
            mis_d   = |redir_tgt[1:0];
            epc_cap = exc_take;
            state_d = ST_FETCH;
          end else if (stall) begin
            if_valid = 1'b1;
            pc_next  = pc_cur;
          end else begin
            if_valid = 1'b1;
            pc_next  = pc_inc;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed stimulus, a behavioural model
// checked every cycle, and hand-computed PC/count expectations.
module tb_pc_sequencer;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_cur = 32'h0;
  logic          imem_ready, stall, branch_taken, jump, exc_req, eret;
  logic [31:0]   branch_target, jump_target;
  logic [31:0]   pc_next, epc;
  logic          imem_req, if_valid, misalign_err;
  logic [CW-1:0] fetch_count;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(.EXC_VECTOR(32'h0000_0080), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .exc_req(exc_req), .eret(eret), .pc_next(pc_next),
    .imem_req(imem_req), .if_valid(if_valid), .misalign_err(misalign_err), .epc(epc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // The program-counter register the block drives
  always @(posedge clk) pc_cur <= pc_next;

  // Behavioural model: booting / holding flags plus counters
  logic          m_boot = 1'b1, m_hold = 1'b0, m_mis = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic [31:0]   m_epc = 32'h0;
  logic [31:0]   e_pc_next, tgt, n_epc;
  logic          e_req, e_valid, n_boot, n_hold, n_mis, have, is_exc;
  logic [CW-1:0] n_cnt;

  always_comb begin
    e_pc_next = 32'h0; e_req = 1'b0; e_valid = 1'b0;
    n_boot = m_boot; n_hold = m_hold; n_cnt = m_cnt; n_epc = m_epc; n_mis = 1'b0;
    have = 1'b1; tgt = 32'h0; is_exc = 1'b0;
`ifdef PC_SEQ_EXC_EN
    if (exc_req) begin tgt = 32'h80; is_exc = 1'b1; end
    else if (eret) tgt = m_epc;
    else if (jump) tgt = jump_target;
    else if (branch_taken) tgt = branch_target;
    else have = 1'b0;
`else
    if (jump) tgt = jump_target;
    else if (branch_taken) tgt = branch_target;
    else have = 1'b0;
`endif
    if (reset) begin
      n_boot = 1'b1; n_hold = 1'b0; n_cnt = '0; n_epc = 32'h0;
    end else if (m_boot) begin
      n_boot = 1'b0;
    end else begin
      e_req = !m_hold;
      if (have) begin
        e_pc_next = tgt & 32'hFFFF_FFFC;
        n_hold = 1'b0;
        n_mis = (tgt[1:0] != 2'b00);
        if (is_exc) n_epc = pc_cur;
      end else if (m_hold || imem_ready) begin
        e_valid = 1'b1;
        if (stall) begin
          e_pc_next = pc_cur; n_hold = 1'b1;
        end else begin
          e_pc_next = pc_cur + 32'd4; n_cnt = m_cnt + CW'(1); n_hold = 1'b0;
        end
      end else begin
        e_pc_next = pc_cur;
      end
    end
  end

  always @(posedge clk) begin
    m_boot <= n_boot; m_hold <= n_hold; m_cnt <= n_cnt; m_epc <= n_epc; m_mis <= n_mis;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_pc_next", pc_next, e_pc_next);
    chk("m_imem_req", 32'(imem_req), 32'(e_req));
    chk("m_if_valid", 32'(if_valid), 32'(e_valid));
    chk("m_misalign", 32'(misalign_err), 32'(m_mis));
    chk("m_epc", epc, m_epc);
    chk("m_count", 32'(fetch_count), 32'(m_cnt));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    exc_req = 1'b0; eret = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
    tick(2);
    chk("rst_count", 32'(fetch_count), 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);

    // Straight-line fetch after one BOOT cycle
    reset = 1'b0; imem_ready = 1'b1; #1;
    chk("boot_req", 32'(imem_req), 32'h0);
    tick(1); chk("seq_pc0", pc_cur, 32'h0); chk("seq_req", 32'(imem_req), 32'h1);
    tick(1); chk("seq_pc4", pc_cur, 32'h4);
    tick(1); chk("seq_pc8", pc_cur, 32'h8); chk("seq_cnt2", 32'(fetch_count), 32'h2);

    // Memory wait, then stall into HOLD, then release
    imem_ready = 1'b0; tick(3); chk("wait_pc", pc_cur, 32'h8);
    imem_ready = 1'b1; stall = 1'b1; tick(1);
    chk("hold_pc", pc_cur, 32'h8); chk("hold_valid", 32'(if_valid), 32'h1);
    chk("hold_req", 32'(imem_req), 32'h0);
    tick(1); chk("hold_pc2", pc_cur, 32'h8);
    stall = 1'b0; #1; chk("release_valid", 32'(if_valid), 32'h1);
    tick(1); chk("release_pc", pc_cur, 32'hC); chk("release_cnt", 32'(fetch_count), 32'h3);

    // Jump beats branch, stall ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h100;
    #1; chk("redir_valid", 32'(if_valid), 32'h0);
    tick(1); chk("redir_pc", pc_cur, 32'h100); chk("redir_cnt", 32'(fetch_count), 32'h3);
    stall = 1'b0; jump = 1'b0;

    // Misaligned branch target
    branch_target = 32'h46; tick(1);
    chk("mis_pc", pc_cur, 32'h44); chk("mis_pulse", 32'(misalign_err), 32'h1);
    branch_taken = 1'b0; tick(1);
    chk("mis_pc2", pc_cur, 32'h48); chk("mis_clear", 32'(misalign_err), 32'h0);
    chk("mis_cnt", 32'(fetch_count), 32'h4);

    // Exception and return
    jump = 1'b1; jump_target = 32'h20; tick(1); chk("exc_setup", pc_cur, 32'h20);
    jump = 1'b0; exc_req = 1'b1; tick(1);
`ifdef PC_SEQ_EXC_EN
    chk("exc_pc", pc_cur, 32'h80); chk("exc_epc", epc, 32'h20);
`else
    chk("exc_pc", pc_cur, 32'h24); chk("exc_epc", epc, 32'h0);
`endif
    exc_req = 1'b0; tick(1);
    eret = 1'b1; tick(1);
`ifdef PC_SEQ_EXC_EN
    chk("eret_pc", pc_cur, 32'h20);
`else
    chk("eret_pc", pc_cur, 32'h2C); chk("eret_epc", epc, 32'h0);
`endif
    eret = 1'b0;

    // Wrap at top of address space, then reset from HOLD
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; tick(1); chk("wrap_top", pc_cur, 32'hFFFF_FFFC);
    jump = 1'b0; tick(1); chk("wrap_pc", pc_cur, 32'h0);
    stall = 1'b1; tick(1); chk("wrap_hold", 32'(if_valid), 32'h1);
    reset = 1'b1; #1;
    chk("rst_hold_pc_next", pc_next, 32'h0); chk("rst_hold_valid", 32'(if_valid), 32'h0);
    tick(1); chk("rst_hold_cnt", 32'(fetch_count), 32'h0);
    reset = 1'b0; stall = 1'b0; #1; chk("reboot_req", 32'(imem_req), 32'h0);
    tick(1); chk("reboot_req2", 32'(imem_req), 32'h1); chk("reboot_pc", pc_cur, 32'h0);

    // Counter wraps after 2^CW transfers
    tick(16);
    chk("cnt_wrap_pc", pc_cur, 32'h40); chk("cnt_wrap", 32'(fetch_count), 32'h0);
    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
